// File: rtl/ray_march_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ray_march_ctrl
//  Purpose  : Iterative sphere-tracing controller. Accepts one ray, issues
//             position queries to a distance-field evaluator, advances the
//             ray by each returned distance and reports hit/miss with a
//             one-cycle result strobe.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              : clock, rising edge
//    rst              : asynchronous reset, active low
//    start            : ray request, accepted only while ready = 1
//    ray_origin       : ray origin        {z, y, x}, each signed Q8.24
//    ray_dir          : unit direction    {z, y, x}, each signed Q8.24
//    obj_sel_in       : object select (0 sphere, 1 cube)
//    ready            : high in IDLE only
//    query_valid      : one-cycle query strobe
//    query_pos        : current ray position {z, y, x}
//    query_obj_sel    : latched object select
//    query_dist       : returned signed distance (Q8.24)
//    query_dist_valid : returned distance strobe
//    result_valid     : one-cycle result strobe
//    hit              : 1 = surface hit, 0 = miss
//    hit_pos          : final position {z, y, x}
//    hit_t            : accumulated distance along the ray
//    step_count       : number of queries issued for this ray
// ============================================================================
module ray_march_ctrl #(
  parameter int unsigned MAX_STEPS = 64,
  parameter logic [31:0] EPSILON   = 32'h00004189,
  parameter logic [31:0] MAX_DIST  = 32'h14000000,
  localparam int unsigned CNT_W    = $clog2(MAX_STEPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [95:0]      ray_origin,
  input  logic [95:0]      ray_dir,
  input  logic             obj_sel_in,
  output logic             ready,
  output logic             query_valid,
  output logic [95:0]      query_pos,
  output logic             query_obj_sel,
  input  logic [31:0]      query_dist,
  input  logic             query_dist_valid,
  output logic             result_valid,
  output logic             hit,
  output logic [95:0]      hit_pos,
  output logic [31:0]      hit_t,
  output logic [CNT_W-1:0] step_count
);

  localparam logic [CNT_W-1:0] c_max_steps = CNT_W'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_QUERY = 3'd1,
    S_WAIT  = 3'd2,
    S_STEP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  // Per-axis vectors are packed {z, y, x} so they map directly onto the ports.
  logic [2:0][31:0] r_p;
  logic [2:0][31:0] r_dir;
  logic [2:0][31:0] w_p_next;
  logic             r_obj;
  logic [31:0]      r_t;
  logic [31:0]      r_d;
  logic [31:0]      w_t_next;
  logic [CNT_W-1:0] r_cnt;

  logic             r_hit;
  logic [2:0][31:0] r_hit_pos;
  logic [31:0]      r_hit_t;
  logic [CNT_W-1:0] r_step_count;

  logic w_is_hit;
  logic w_budget_out;
  logic w_too_far;

  // Signed compare: a negative distance means the position is already inside.
  assign w_is_hit     = $signed(query_dist) < $signed(EPSILON);
  // Counter already holds the number of queries issued, including this one.
  assign w_budget_out = (r_cnt == c_max_steps);
  assign w_t_next     = r_t + r_d;
  assign w_too_far    = $signed(w_t_next) > $signed(MAX_DIST);

  // p += dir * d per axis. A 64x64 multiply of sign-extended operands gives
  // the exact 32x32 signed product in its low 64 bits; bits [55:24] realign
  // Q16.48 back to Q8.24 with floor (arithmetic) truncation.
  for (genvar i = 0; i < 3; i++) begin : g_axis
    logic signed [63:0] w_dir_ext;
    logic signed [63:0] w_d_ext;
    logic signed [63:0] w_prod;
    logic               w_unused_bits;

    assign w_dir_ext     = {{32{r_dir[i][31]}}, r_dir[i]};
    assign w_d_ext       = {{32{r_d[31]}}, r_d};
    assign w_prod        = w_dir_ext * w_d_ext;
    assign w_p_next[i]   = r_p[i] + w_prod[55:24];
    assign w_unused_bits = ^{w_prod[63:56], w_prod[23:0]};
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and state-decoded strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_next       = r_state;
    ready        = 1'b0;
    query_valid  = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_next = S_QUERY;
        end
      end
      S_QUERY: begin
        query_valid = 1'b1;
        w_next      = S_WAIT;
      end
      S_WAIT: begin
        if (query_dist_valid) begin
          if (w_is_hit || w_budget_out) begin
            w_next = S_DONE;
          end else begin
            w_next = S_STEP;
          end
        end
      end
      S_STEP: begin
        w_next = w_too_far ? S_DONE : S_QUERY;
      end
      S_DONE: begin
        result_valid = 1'b1;
        w_next       = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Ray datapath and result registers. Result registers are written only on
  // the transitions into DONE, so they hold until the next ray completes.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p          <= '0;
      r_dir        <= '0;
      r_obj        <= 1'b0;
      r_t          <= '0;
      r_d          <= '0;
      r_cnt        <= '0;
      r_hit        <= 1'b0;
      r_hit_pos    <= '0;
      r_hit_t      <= '0;
      r_step_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_p   <= ray_origin;
            r_dir <= ray_dir;
            r_obj <= obj_sel_in;
            r_t   <= '0;
            r_cnt <= '0;
          end
        end
        S_QUERY: begin
          r_cnt <= r_cnt + 1'b1;
        end
        S_WAIT: begin
          if (query_dist_valid) begin
            if (w_is_hit || w_budget_out) begin
              r_hit        <= w_is_hit;
              r_hit_pos    <= r_p;
              r_hit_t      <= r_t;
              r_step_count <= r_cnt;
            end else begin
              r_d <= query_dist;
            end
          end
        end
        S_STEP: begin
          r_p <= w_p_next;
          r_t <= w_t_next;
          if (w_too_far) begin
            r_hit        <= 1'b0;
            r_hit_pos    <= w_p_next;
            r_hit_t      <= w_t_next;
            r_step_count <= r_cnt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign query_pos     = r_p;
  assign query_obj_sel = r_obj;
  assign hit           = r_hit;
  assign hit_pos       = r_hit_pos;
  assign hit_t         = r_hit_t;
  assign step_count    = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_ray_march_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ray_march_ctrl
//  Purpose  : Self-checking bench for ray_march_ctrl with a behavioural
//             distance responder and a result scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ray_march_ctrl;

  localparam int MAX_STEPS = 4;
  localparam int CW        = $clog2(MAX_STEPS + 1);

  typedef struct {
    logic          h;
    logic [95:0]   pos;
    logic [31:0]   t;
    logic [CW-1:0] steps;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [95:0]   ray_origin;
  logic [95:0]   ray_dir;
  logic          obj_sel_in;
  logic          ready;
  logic          query_valid;
  logic [95:0]   query_pos;
  logic          query_obj_sel;
  logic [31:0]   query_dist;
  logic          query_dist_valid;
  logic          result_valid;
  logic          hit;
  logic [95:0]   hit_pos;
  logic [31:0]   hit_t;
  logic [CW-1:0] step_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t m_e;
  int   nq   = 0;
  int   mode = 0;
  int   lat  = 1;
  int   qidx = 0;

  ray_march_ctrl #(
    .MAX_STEPS(MAX_STEPS)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .ray_origin       (ray_origin),
    .ray_dir          (ray_dir),
    .obj_sel_in       (obj_sel_in),
    .ready            (ready),
    .query_valid      (query_valid),
    .query_pos        (query_pos),
    .query_obj_sel    (query_obj_sel),
    .query_dist       (query_dist),
    .query_dist_valid (query_dist_valid),
    .result_valid     (result_valid),
    .hit              (hit),
    .hit_pos          (hit_pos),
    .hit_t            (hit_t),
    .step_count       (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distance model per scenario
  function automatic logic [31:0] model(input int md, input int idx, input logic [95:0] pos);
    logic signed [31:0] z;
    logic signed [31:0] a;
    z = pos[95:64];
    a = (z < 0) ? -z : z;
    case (md)
      0: return a - 32'sh01000000;                       // unit sphere on z axis
      1: return 32'h00800000;                            // 0.5
      2: return 32'h08000000;                            // 8.0
      3: return 32'hFFC00000;                            // -0.25
      4: return (idx == 0) ? 32'h00004189 : 32'h0;       // exactly EPSILON, then 0
      5: return (idx < 2) ? 32'h0A000000 : 32'h0;        // 10, 10, then 0
      default: return 32'h0;
    endcase
  endfunction

  // Responder: answers each query lat cycles later with a one-cycle strobe
  initial begin
    logic [95:0] p;
    int          id;
    query_dist       = '0;
    query_dist_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (query_valid) begin
        p  = query_pos;
        id = qidx;
        qidx++;
        repeat (lat) @(negedge clk);
        query_dist       = model(mode, id, p);
        query_dist_valid = 1'b1;
        @(negedge clk);
        query_dist_valid = 1'b0;
        query_dist       = '0;
      end
    end
  end

  // Result monitor: pops the scoreboard on every result strobe
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        nq = 0;
      end else begin
        if (query_valid) nq++;
        if (result_valid) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result: result_valid=1 seen, required no result");
          end else begin
            m_e = sb.pop_front();
            n_checks++;
            if (hit !== m_e.h) begin
              n_fail++;
              $display("FAIL result_hit: got %b, required %b", hit, m_e.h);
            end
            n_checks++;
            if (hit_pos !== m_e.pos) begin
              n_fail++;
              $display("FAIL result_hit_pos: got %h, required %h", hit_pos, m_e.pos);
            end
            n_checks++;
            if (hit_t !== m_e.t) begin
              n_fail++;
              $display("FAIL result_hit_t: got %h, required %h", hit_t, m_e.t);
            end
            n_checks++;
            if (step_count !== m_e.steps) begin
              n_fail++;
              $display("FAIL result_step_count: got %0d, required %0d", step_count, m_e.steps);
            end
            n_checks++;
            if (nq != int'(m_e.steps)) begin
              n_fail++;
              $display("FAIL query_pulses: got %0d, required %0d", nq, m_e.steps);
            end
          end
          nq = 0;
        end
      end
    end
  end

  // Drive one ray from a negedge while IDLE, recording its expected result
  task automatic launch(input logic [95:0] o, input logic [95:0] d, input logic obj,
                        input int md, input int l, input exp_t e);
    mode       = md;
    lat        = l;
    qidx       = 0;
    ray_origin = o;
    ray_dir    = d;
    obj_sel_in = obj;
    start      = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int budget, output bit timed_out);
    for (int k = 0; k < budget; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    #1;
    timed_out = (sb.size() != 0);
    sb.delete();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || query_valid !== 1'b0 || result_valid !== 1'b0 || hit !== 1'b0 ||
        hit_pos !== '0 || hit_t !== '0 || step_count !== '0 || query_pos !== '0 ||
        query_obj_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b qv=%b rv=%b hit=%b pos=%h t=%h sc=%0d qpos=%h qsel=%b, required ready=1 and all others 0",
               ready, query_valid, result_valid, hit, hit_pos, hit_t, step_count, query_pos, query_obj_sel);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic test_sphere_hit();
    exp_t e;
    int   res_cyc;
    bit   to;
    e.h = 1'b1; e.pos = {32'hFF000000, 32'h0, 32'h0}; e.t = 32'h02000000; e.steps = CW'(2);
    res_cyc = -1;
    launch({32'hFD000000, 32'h0, 32'h0}, {32'h01000000, 32'h0, 32'h0}, 1'b0, 0, 2, e);
    // now in cycle 1 after the accepting edge
    n_checks++;
    if (query_valid !== 1'b1 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL sphere_first_query: query_valid=%b ready=%b, required 1 and 0", query_valid, ready);
    end
    for (int k = 2; k <= 30; k++) begin
      @(negedge clk);
      if (result_valid) begin
        res_cyc = k;
        break;
      end
    end
    n_checks++;
    if (res_cyc != 8) begin
      n_fail++;
      $display("FAIL sphere_result_cycle: got %0d, required 8", res_cyc);
    end
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL sphere_ready_after_done: got %b, required 1", ready);
    end
    drain(20, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL sphere_timeout: result missing, required one result"); end
  endtask

  task automatic test_step_budget();
    exp_t e;
    bit   to;
    e.h = 1'b0; e.pos = {32'h0, 32'h01333332, 32'h00E66667}; e.t = 32'h01800000; e.steps = CW'(4);
    launch('0, {32'h0, 32'h00CCCCCD, 32'h0099999A}, 1'b1, 1, 1, e);
    drain(100, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL budget_timeout: result missing, required one result"); end
  endtask

  task automatic test_max_dist();
    exp_t e;
    bit   to;
    e.h = 1'b0; e.pos = {32'h0, 32'h18000000, 32'h0}; e.t = 32'h18000000; e.steps = CW'(3);
    launch('0, {32'h0, 32'h01000000, 32'h0}, 1'b0, 2, 3, e);
    drain(100, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL maxdist_timeout: result missing, required one result"); end
  endtask

  task automatic test_negative_dist();
    exp_t e;
    bit   to;
    e.h = 1'b1; e.pos = {32'hFD000000, 32'h02000000, 32'h00100000}; e.t = 32'h0; e.steps = CW'(1);
    launch({32'hFD000000, 32'h02000000, 32'h00100000}, {32'h0, 32'h0, 32'h01000000}, 1'b1, 3, 1, e);
    drain(50, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL negative_timeout: result missing, required one result"); end
  endtask

  task automatic test_epsilon_boundary();
    exp_t e;
    bit   to;
    e.h = 1'b1; e.pos = {32'h0, 32'h0, 32'h00004189}; e.t = 32'h00004189; e.steps = CW'(2);
    launch('0, {32'h0, 32'h0, 32'h01000000}, 1'b0, 4, 2, e);
    drain(50, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL epsilon_timeout: result missing, required one result"); end
  endtask

  task automatic test_max_dist_boundary();
    exp_t e;
    bit   to;
    e.h = 1'b1; e.pos = {32'h14000000, 32'h0, 32'h0}; e.t = 32'h14000000; e.steps = CW'(3);
    launch('0, {32'h01000000, 32'h0, 32'h0}, 1'b0, 5, 1, e);
    drain(50, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL maxdist_edge_timeout: result missing, required one result"); end
  endtask

  task automatic test_reset_in_flight();
    int bad;
    mode = 3; lat = 3; qidx = 0;
    ray_origin = {32'h01000000, 32'h01000000, 32'h01000000};
    ray_dir    = {32'h01000000, 32'h0, 32'h0};
    obj_sel_in = 1'b1;
    start      = 1'b1;
    @(negedge clk);            // cycle 1: QUERY
    start = 1'b0;
    n_checks++;
    if (query_valid !== 1'b1 || query_obj_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL inflight_query: query_valid=%b obj_sel=%b, required 1 and 1", query_valid, query_obj_sel);
    end
    @(negedge clk);            // cycle 2: WAIT
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;                // response arrives in cycle 4, after release
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (result_valid || query_valid) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL inflight_strobes: got %0d strobe cycles, required 0", bad);
    end
    n_checks++;
    if (ready !== 1'b1 || hit !== 1'b0 || hit_pos !== '0 || hit_t !== '0 ||
        step_count !== '0 || query_pos !== '0 || query_obj_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_idle: ready=%b hit=%b pos=%h t=%h sc=%0d qpos=%h qsel=%b, required ready=1 and all others 0",
               ready, hit, hit_pos, hit_t, step_count, query_pos, query_obj_sel);
    end
    #1;
  endtask

  task automatic test_back_to_back();
    exp_t ea;
    exp_t eb;
    int   seen;
    bit   to;
    ea.h = 1'b1; ea.pos = {32'hFF000000, 32'h0, 32'h0}; ea.t = 32'h02000000; ea.steps = CW'(2);
    eb.h = 1'b1; eb.pos = {32'hFF000000, 32'h0, 32'h0}; eb.t = 32'h04000000; eb.steps = CW'(2);
    mode = 0; lat = 1; qidx = 0;
    ray_origin = {32'hFD000000, 32'h0, 32'h0};
    ray_dir    = {32'h01000000, 32'h0, 32'h0};
    obj_sel_in = 1'b0;
    start      = 1'b1;
    sb.push_back(ea);
    @(negedge clk);
    ray_origin = {32'hFB000000, 32'h0, 32'h0};   // second ray, start kept high
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ready_fall: got %b, required 0", ready);
    end
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (seen != 1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_first_done: ready_seen=%0d pending=%0d, required 1 and 0", seen, sb.size());
    end
    sb.push_back(eb);
    qidx = 0;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (ready !== 1'b0 || query_valid !== 1'b1 || query_pos !== {32'hFB000000, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL b2b_second_accept: ready=%b qv=%b qpos=%h, required 0 1 %h",
               ready, query_valid, query_pos, {32'hFB000000, 32'h0, 32'h0});
    end
    drain(60, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL b2b_timeout: result missing, required one result"); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; ray_origin = '0; ray_dir = '0; obj_sel_in = 1'b0;
    test_reset();
    test_sphere_hit();
    test_step_budget();
    test_max_dist();
    test_negative_dist();
    test_epsilon_boundary();
    test_max_dist_boundary();
    test_reset_in_flight();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/ray_march_ctrl.md
# ray_march_ctrl

Iterative sphere-tracing controller that sits directly upstream of `sceneQuery` and consumes its output. It accepts one ray (origin, unit direction, object select), issues position queries to `sceneQuery`, and advances the ray by each returned distance. It terminates on a hit, when the maximum distance is exceeded, or when the step budget is exhausted, then reports the result with a one-cycle pulse.

## Interface
- `MAX_STEPS`, 64: maximum queries per ray (≥1).
- `EPSILON`, 32'h00004189 (≈0.001, Q8.24): hit threshold.
- `MAX_DIST`, 32'h14000000 (20.0, Q8.24): miss threshold on accumulated t.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: ray request; accepted only when `ready`=1.
- `ray_origin`, in, vec3: ray origin.
- `ray_dir`, in, vec3: unit direction.
- `obj_sel_in`, in, 1: object select (0 sphere, 1 cube).
- `ready`, out, 1: high in IDLE only.
- `query_valid`, out, 1: one-cycle query strobe to `sceneQuery.valid_in`.
- `query_pos`, out, vec3: current position, to `sceneQuery.pos`.
- `query_obj_sel`, out, 1: latched object select, to `sceneQuery.obj_sel`.
- `query_dist`, in, fp: from `sceneQuery.closestDistance`.
- `query_dist_valid`, in, 1: from `sceneQuery.valid_out`.
- `result_valid`, out, 1: one-cycle result strobe.
- `hit`, out, 1: 1 = surface hit, 0 = miss.
- `hit_pos`, out, vec3: final position.
- `hit_t`, out, fp: accumulated distance.
- `step_count`, out, $clog2(MAX_STEPS+1): number of queries issued for this ray.

## Operation
- All fp values are signed Q8.24.
- FSM states: IDLE, QUERY, WAIT, STEP, DONE.
- IDLE: on `start`, latch origin into p, dir, and obj_sel; clear t and step counter; go to QUERY. A `start` in any other state is ignored.
- QUERY: assert `query_valid` with `query_pos`=p for exactly one cycle; increment the step counter; go to WAIT.
- WAIT: hold until `query_dist_valid`=1. `query_dist_valid` is ignored in every other state. Let d = `query_dist`.
  - d < EPSILON (signed compare, so negative d counts as a hit): hit=1, go to DONE.
  - Otherwise, if the step counter equals MAX_STEPS: hit=0, go to DONE.
  - Otherwise: latch d and go to STEP.
- STEP: per axis, p += (dir·d). Each product is a 32×32 signed multiply to 64 bits; take bits [55:24] (arithmetic truncation). Also t += d, with no saturation.
  - If the new t > MAX_DIST: hit=0, go to DONE.
  - Otherwise go to QUERY.
- DONE: `result_valid`=1 for one cycle; `hit`, `hit_pos`, `hit_t`, `step_count` are valid and held until the next accepted `start`. Return to IDLE.
- Reset (any state, asynchronous): state=IDLE, `ready`=1, all other outputs 0, internal registers 0. A query in flight is abandoned and its late `query_dist_valid` is ignored; no `result_valid` is produced.

## Timing
- `start` sampled at edge 0 → `query_valid` high in cycle 1.
- With `sceneQuery` latency L ≥ 1, the response arrives in cycle 1+L.
- Continue: STEP in cycle 2+L, next `query_valid` in cycle 3+L. Iteration period is L+2 cycles.
- Hit or step-budget miss: `result_valid` in cycle 2+L after the final query.
- MAX_DIST miss: `result_valid` one cycle after STEP.
- `ready` falls the cycle after `start` is accepted and rises the cycle after DONE.
- Output registers update only on the transition into DONE.

## Test plan
- Sphere (r=1) via `sceneQuery`, origin (0,0,-3), dir (0,0,1): queries return 2.0 then 0.0 → hit=1, step_count=2, hit_t=2.0 (32'h02000000), hit_pos z=-1.0 (32'hFF000000).
- Bench model returns constant 0.5, EPSILON=0, MAX_STEPS=4 → four `query_valid` pulses, then result with hit=0, step_count=4, hit_t=1.5 (budget is checked before the 4th step).
- Model returns constant 8.0, MAX_DIST=20.0 → after the 3rd step t=24.0 > 20.0: hit=0, step_count=3, hit_t=32'h18000000.
- Model returns -0.25 on the first query → hit=1, step_count=1, hit_t=0, hit_pos=origin.
- Drive `rst` low during WAIT with L=3, then release; model responds after release → no `result_valid`, `ready`=1, all outputs 0, FSM stays in IDLE.
- Assert `start` continuously during a ray with a different origin → only the first ray is processed; results match the first ray; the second `start` is accepted only once `ready`=1.
